// File: rtl/twiddle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_pkg
// Description : Shared types, constants and the elaboration-time quarter-wave
//               cosine generator used by the twiddle-factor generator.
//               Contents:
//                 cplx_t             packed {re, im} complex sample
//                 quad_t             quadrant enum Q0..Q3
//                 tw_quarter_depth() number of quarter-table entries (Q+1)
//                 tw_quarter_value() round(cos(2*pi*i/N) * (2^(W-1)-1))
// Revision    : 1.0 - initial release
// ============================================================================
package twiddle_pkg;

    localparam int c_TW_LOG2N = 11;
    localparam int c_TW_W     = 16;
    localparam int c_TW_Q     = 1 << (c_TW_LOG2N - 2);

    localparam real c_PI = 3.14159265358979323846;

    typedef struct packed {
        logic signed [c_TW_W-1:0] re;
        logic signed [c_TW_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    // Quarter-wave table holds indices 0..Q inclusive.
    function automatic int tw_quarter_depth(input int log2n);
        return (1 << (log2n - 2)) + 1;
    endfunction

    // Evaluated only at elaboration.  A Taylor series keeps this free of
    // math-library calls; 20 terms are far beyond double precision on
    // the [0, pi/2] interval, so rounding matches an exact cosine.
    function automatic int tw_quarter_value(input int i, input int log2n, input int w);
        real x;
        real term;
        real sum;
        real scale;
        x     = 2.0 * c_PI * real'(i) / real'(1 << log2n);
        scale = real'((1 << (w - 1)) - 1);
        term  = 1.0;
        sum   = 1.0;
        for (int n = 1; n <= 20; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        // Values are non-negative on the quarter wave; +0.5 then truncate
        // rounds to nearest.  A tiny negative residue at i = Q rounds to 0.
        return $rtoi(sum * scale + 0.5);
    endfunction

endpackage : twiddle_pkg
`default_nettype wire

// File: rtl/twiddle_quarter_rom.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_quarter_rom
// Description : Quarter-wave cosine table, Q+1 entries, two synchronous read
//               ports sharing one read enable.  Contents are fixed at
//               elaboration from tw_quarter_value().
// Ports       : clk            clock
//               en             read enable; outputs hold when low
//               addr_a/addr_b  table indices, 0..Q
//               data_a/data_b  registered table values (non-negative)
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_quarter_rom
    import twiddle_pkg::*;
#(
    parameter int LOG2N = 11,
    parameter int W     = 16
) (
    input  logic             clk,
    input  logic             en,
    input  logic [LOG2N-2:0] addr_a,
    input  logic [LOG2N-2:0] addr_b,
    output logic [W-1:0]     data_a,
    output logic [W-1:0]     data_b
);

    localparam int c_DEPTH = tw_quarter_depth(LOG2N);

    logic [W-1:0] w_table [0:c_DEPTH-1];

    for (genvar g = 0; g < c_DEPTH; g++) begin : g_entry
        localparam int c_VAL = tw_quarter_value(g, LOG2N, W);
        assign w_table[g] = W'(c_VAL);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= w_table[addr_a];
            data_b <= w_table[addr_b];
        end
    end

endmodule : twiddle_quarter_rom
`default_nettype wire

// File: rtl/twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_gen
// Description : Radix-r twiddle generator.  For each accepted request it
//               returns NCH twiddles W_N^(m*e), m = 1..NCH, built from one
//               quarter-wave cosine table per lane with quadrant folding.
//               Valid/ready pipeline with a single global advance enable.
// Ports       : clk, rst            clock, synchronous active-high reset
//               in_valid/in_ready   request handshake
//               k_i, stride_i       base exponent and its left shift
//               conj_i              (TWIDDLE_CONJ_EN only) conjugate output
//               out_valid/out_ready result handshake
//               tw_o[NCH]           {re, im} per lane, signed Q1.(W-1)
// Build macro : TWIDDLE_CONJ_EN adds conj_i; undefined means im = -sin.
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter int LOG2N = 11,
    parameter int W     = 16,
    parameter int NCH   = 3,
    parameter int SW    = $clog2(LOG2N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOG2N-1:0] k_i,
    input  logic [SW-1:0]    stride_i,
`ifdef TWIDDLE_CONJ_EN
    input  logic             conj_i,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   tw_o [NCH]
);

    localparam int c_Q  = 1 << (LOG2N - 2);
    localparam int c_RW = LOG2N - 2;   // in-quadrant offset width
    localparam int c_AW = LOG2N - 1;   // table address width (0..Q)

    logic             w_en;
    logic             w_conj;
    logic [LOG2N-1:0] w_base;

    // Request stage: base exponent and sideband captured on acceptance.
    logic             r_v0;
    logic [LOG2N-1:0] r_base0;
    logic             r_conj0;
    // Exponent / ROM stage valids and sideband.
    logic             r_v1;
    logic             r_conj1;
    logic             r_v2;
    logic             r_conj2;

    // A stalled output blocks the whole pipe; bubbles are never squeezed out.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Shift result is truncated to LOG2N bits, i.e. taken mod N.
    assign w_base = k_i << stride_i;

`ifdef TWIDDLE_CONJ_EN
    assign w_conj = conj_i;
`else
    assign w_conj = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            out_valid <= 1'b0;
            r_base0   <= '0;
            r_conj0   <= 1'b0;
            r_conj1   <= 1'b0;
            r_conj2   <= 1'b0;
        end else if (w_en) begin
            r_v0      <= in_valid;
            r_base0   <= w_base;
            r_conj0   <= w_conj;
            r_v1      <= r_v0;
            r_conj1   <= r_conj0;
            r_v2      <= r_v1;
            r_conj2   <= r_conj1;
            out_valid <= r_v2;
        end
    end

    for (genvar m = 0; m < NCH; m++) begin : g_lane
        logic [LOG2N-1:0]    w_exp;
        quad_t               r_q1;
        logic [c_RW-1:0]     r_r1;
        quad_t               r_q2;
        logic [c_AW-1:0]     w_addr_a;
        logic [c_AW-1:0]     w_addr_b;
        logic [W-1:0]        w_rom_a;
        logic [W-1:0]        w_rom_b;
        logic signed [W-1:0] w_a;
        logic signed [W-1:0] w_b;
        logic signed [W-1:0] w_cos;
        logic signed [W-1:0] w_sin;
        logic signed [W-1:0] w_im;
        logic [2*W-1:0]      r_tw;

        // Lane exponent (m+1)*b, wrapping mod N by truncation.
        assign w_exp = LOG2N'((m + 1) * int'(w_base_lane()));

        function automatic logic [LOG2N-1:0] w_base_lane();
            return r_base0;
        endfunction

        always_ff @(posedge clk) begin
            if (w_en) begin
                r_q1 <= quad_t'(w_exp[LOG2N-1:LOG2N-2]);
                r_r1 <= w_exp[c_RW-1:0];
                r_q2 <= r_q1;
            end
        end

        // Second read mirrors the first about Q; r = 0 legitimately hits T[Q].
        assign w_addr_a = {1'b0, r_r1};
        assign w_addr_b = c_AW'(c_Q) - {1'b0, r_r1};

        twiddle_quarter_rom #(
            .LOG2N (LOG2N),
            .W     (W)
        ) u_rom (
            .clk    (clk),
            .en     (w_en),
            .addr_a (w_addr_a),
            .addr_b (w_addr_b),
            .data_a (w_rom_a),
            .data_b (w_rom_b)
        );

        assign w_a = w_rom_a;
        assign w_b = w_rom_b;

        always_comb begin
            w_cos = '0;
            w_sin = '0;
            case (r_q2)
                Q0: begin w_cos = w_a;  w_sin = w_b;  end
                Q1: begin w_cos = -w_b; w_sin = w_a;  end
                Q2: begin w_cos = -w_a; w_sin = -w_b; end
                Q3: begin w_cos = w_b;  w_sin = -w_a; end
                default: begin w_cos = '0; w_sin = '0; end
            endcase
        end

        // Forward twiddle uses -sin; the conjugate (inverse FFT) keeps +sin.
        assign w_im = r_conj2 ? w_sin : -w_sin;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_tw <= '0;
            end else if (w_en) begin
                r_tw <= {w_cos, w_im};
            end
        end

        assign tw_o[m] = r_tw;
    end

endmodule : twiddle_gen
`default_nettype wire

// File: tb/tb_twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_gen
// Description : Self-checking bench for twiddle_gen (LOG2N=11, W=16, NCH=3).
//               Expected twiddles come from a real-valued cos/sin model kept
//               in a scoreboard queue; directed cases use literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_gen;
    import twiddle_pkg::*;

    localparam int c_N   = 2048;
    localparam int c_NCH = 3;

    typedef logic [c_NCH-1:0][31:0] lanes_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] k_i;
    logic [3:0]  stride_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] tw_o [c_NCH];
`ifdef TWIDDLE_CONJ_EN
    logic        conj;
`endif

    lanes_t sb[$];
    int     n_vec = 0;
    int     n_err = 0;

    always #5 clk = ~clk;

    twiddle_gen #(
        .LOG2N (11),
        .W     (16),
        .NCH   (3),
        .SW    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .k_i       (k_i),
        .stride_i  (stride_i),
`ifdef TWIDDLE_CONJ_EN
        .conj_i    (conj),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tw_o      (tw_o)
    );

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic logic [31:0] gold_lane(input int e, input logic c);
        real a;
        int  re;
        int  im;
        a  = 2.0 * 3.14159265358979323846 * real'(e) / real'(c_N);
        re = rnd($cos(a) * 32767.0);
        im = rnd($sin(a) * 32767.0);
        if (!c) im = -im;
        return {re[15:0], im[15:0]};
    endfunction

    function automatic lanes_t gold(input logic [10:0] k, input logic [3:0] s, input logic c);
        lanes_t res;
        int     b;
        b = (int'(k) << s) % c_N;
        for (int m = 0; m < c_NCH; m++) res[m] = gold_lane(((m + 1) * b) % c_N, c);
        return res;
    endfunction

    // One clock cycle: drive inputs, observe before the edge, update scoreboard.
    task automatic step(input logic v, input logic [10:0] k, input logic [3:0] s,
                        input logic c, input logic rdy,
                        output logic ov, output logic ir, output logic acc,
                        output logic popped, output lanes_t obs, output lanes_t expv);
        in_valid  = v;
        k_i       = k;
        stride_i  = s;
        out_ready = rdy;
`ifdef TWIDDLE_CONJ_EN
        conj = c;
`endif
        #1;
        ov     = out_valid;
        ir     = in_ready;
        acc    = v && in_ready;
        popped = 1'b0;
        expv   = 'x;
        for (int m = 0; m < c_NCH; m++) obs[m] = tw_o[m];
        if (out_valid && out_ready) begin
            popped = 1'b1;
            if (sb.size() > 0) expv = sb.pop_front();
        end
        if (acc) sb.push_back(gold(k, s, c));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends a single request into an idle pipe and waits for its result.
    task automatic run_single(input logic [10:0] k, input logic [3:0] s, input logic c,
                              output lanes_t got, output lanes_t expv, output int lat);
        logic   ov, ir, acc, popped;
        lanes_t obs, e;
        lat = -1;
        got = '0;
        expv = 'x;
        step(1'b1, k, s, c, 1'b1, ov, ir, acc, popped, obs, e);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 11'd0, 4'd0, 1'b0, 1'b1, ov, ir, acc, popped, obs, e);
            if (popped && lat < 0) begin
                lat  = i - 1;
                got  = obs;
                expv = e;
            end
        end
    endtask

    task automatic test_reset();
        logic   ov, ir, acc, popped;
        lanes_t obs, e;
        for (int i = 0; i < 3; i++)
            step(1'b1, 11'(100 * i + 7), 4'd0, 1'b0, 1'b1, ov, ir, acc, popped, obs, e);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        for (int m = 0; m < c_NCH; m++) begin
            n_vec++;
            if (tw_o[m] !== 32'd0) begin
                n_err++;
                $display("FAIL reset_tw lane%0d: got %h want 00000000", m, tw_o[m]);
            end
        end
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 11'd0, 4'd0, 1'b0, 1'b1, ov, ir, acc, popped, obs, e);
            n_vec++;
            if (ov !== 1'b0) begin
                n_err++;
                $display("FAIL reset_stale cycle%0d: out_valid got %b want 0", i, ov);
            end
        end
    endtask

    task automatic test_k0();
        lanes_t got, expv;
        int     lat;
        run_single(11'd0, 4'd0, 1'b0, got, expv, lat);
        n_vec++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL k0_latency: got %0d want 3", lat);
        end
        for (int m = 0; m < c_NCH; m++) begin
            n_vec++;
            if (got[m] !== {16'sd32767, 16'sd0}) begin
                n_err++;
                $display("FAIL k0 lane%0d: got re=%0d im=%0d want re=32767 im=0",
                         m, $signed(got[m][31:16]), $signed(got[m][15:0]));
            end
        end
    endtask

    task automatic test_k512();
        lanes_t got, expv, want;
        int     lat;
        want[0] = {16'sd0, -16'sd32767};
        want[1] = {-16'sd32767, 16'sd0};
        want[2] = {16'sd0, 16'sd32767};
        run_single(11'd512, 4'd0, 1'b0, got, expv, lat);
        for (int m = 0; m < c_NCH; m++) begin
            n_vec++;
            if (got[m] !== want[m]) begin
                n_err++;
                $display("FAIL k512 lane%0d: got re=%0d im=%0d want re=%0d im=%0d",
                         m, $signed(got[m][31:16]), $signed(got[m][15:0]),
                         $signed(want[m][31:16]), $signed(want[m][15:0]));
            end
        end
    endtask

    task automatic test_wrap_stride();
        lanes_t      got, expv;
        logic [31:0] w404;
        logic [31:0] w_s;
        int          lat;
        // k = 1500: lane2 exponent 3*1500 mod 2048 = 404.
        w404 = gold_lane(404, 1'b0);
        run_single(11'd1500, 4'd0, 1'b0, got, expv, lat);
        n_vec++;
        if (got[2] !== w404) begin
            n_err++;
            $display("FAIL wrap404 lane2: got re=%0d im=%0d want re=%0d im=%0d",
                     $signed(got[2][31:16]), $signed(got[2][15:0]),
                     $signed(w404[31:16]), $signed(w404[15:0]));
        end
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if (got[m] !== expv[m]) begin
                n_err++;
                $display("FAIL wrap1500 lane%0d: got %h want %h", m, got[m], expv[m]);
            end
        end
        // k = 3, stride = 9: b = 1536, lane0 = (0, +32767).
        w_s = {16'sd0, 16'sd32767};
        run_single(11'd3, 4'd9, 1'b0, got, expv, lat);
        n_vec++;
        if (got[0] !== w_s) begin
            n_err++;
            $display("FAIL stride9 lane0: got re=%0d im=%0d want re=0 im=32767",
                     $signed(got[0][31:16]), $signed(got[0][15:0]));
        end
        for (int m = 1; m < c_NCH; m++) begin
            n_vec++;
            if (got[m] !== expv[m]) begin
                n_err++;
                $display("FAIL stride9 lane%0d: got %h want %h", m, got[m], expv[m]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic        ov, ir, acc, popped, v, rdy, prev_stall;
        logic [10:0] k;
        logic [3:0]  s;
        lanes_t      obs, e, prev_obs;
        int          sent, recv, cyc;
        sent       = 0;
        recv       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_obs   = '0;
        while ((sent < 200 || sb.size() > 0) && cyc < 3000) begin
            v = (sent < 200) && ($urandom_range(0, 9) < 8);
            if (cyc >= 20 && cyc < 25) rdy = 1'b0;
            else rdy = ($urandom_range(0, 3) != 0);
            k = 11'($urandom_range(0, 2047));
            s = 4'($urandom_range(0, 10));
            step(v, k, s, 1'b0, rdy, ov, ir, acc, popped, obs, e);
            if (acc) sent++;
            if (prev_stall) begin
                n_vec++;
                if (ov !== 1'b1 || obs !== prev_obs) begin
                    n_err++;
                    $display("FAIL stall_hold cyc%0d: got valid=%b tw=%h want valid=1 tw=%h",
                             cyc, ov, obs, prev_obs);
                end
            end
            if (ov && !rdy) begin
                n_vec++;
                if (ir !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_in_ready cyc%0d: got %b want 0", cyc, ir);
                end
            end
            if (popped) begin
                recv++;
                n_vec++;
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL stream item%0d: got %h want %h", recv, obs, e);
                end
            end
            prev_stall = ov && !rdy;
            prev_obs   = obs;
            cyc++;
        end
        n_vec++;
        if (recv !== 200 || sb.size() !== 0) begin
            n_err++;
            $display("FAIL stream_count: got %0d received (%0d pending) want 200 (0 pending)",
                     recv, sb.size());
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 11'd0, 4'd0, 1'b0, 1'b1, ov, ir, acc, popped, obs, e);
            n_vec++;
            if (ov !== 1'b0) begin
                n_err++;
                $display("FAIL stream_extra cycle%0d: out_valid got %b want 0", i, ov);
            end
        end
    endtask

`ifdef TWIDDLE_CONJ_EN
    task automatic test_conj();
        lanes_t got, expv;
        int     lat;
        run_single(11'd256, 4'd0, 1'b1, got, expv, lat);
        n_vec++;
        if (got[0] !== {16'sd23170, 16'sd23170}) begin
            n_err++;
            $display("FAIL conj1 lane0: got re=%0d im=%0d want re=23170 im=23170",
                     $signed(got[0][31:16]), $signed(got[0][15:0]));
        end
        n_vec++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL conj1_latency: got %0d want 3", lat);
        end
        run_single(11'd256, 4'd0, 1'b0, got, expv, lat);
        n_vec++;
        if (got[0] !== {16'sd23170, -16'sd23170}) begin
            n_err++;
            $display("FAIL conj0 lane0: got re=%0d im=%0d want re=23170 im=-23170",
                     $signed(got[0][31:16]), $signed(got[0][15:0]));
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        k_i       = '0;
        stride_i  = '0;
        out_ready = 1'b1;
`ifdef TWIDDLE_CONJ_EN
        conj = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_k0();
        test_k512();
        test_wrap_stride();
        test_backpressure();
`ifdef TWIDDLE_CONJ_EN
        test_conj();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_twiddle_gen
`default_nettype wire
